// File: rtl/vram_arbiter_if.sv
// CPU-side request/acknowledge bus of the video RAM arbiter.
// master = CPU bus interface, slave = arbiter.
interface vram_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_req,
    output cpu_we,
    output cpu_wdata,
    input  cpu_ack,
    input  cpu_rdata
  );

  modport slave (
    input  cpu_req,
    input  cpu_we,
    input  cpu_wdata,
    output cpu_ack,
    output cpu_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Time-slot arbiter for the video RAM shared by VGA scan-out and the CPU.
// Ports: pclk/rst, timing (shload_n, video_active, vga_oe_n),
//   CPU bus (cpu interface, slave side), RAM control/data (mem_*),
//   cpu_addr_oe_n address-buffer enable, fetch_miss suppression pulse.
module vram_arbiter #(
  parameter int DATA_W        = 8,
  parameter int ACCESS_CYCLES = 2,
  parameter int FETCH_START   = 5
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              shload_n,
  input  logic              video_active,
  vram_arbiter_if.slave     cpu,
  output logic              vga_oe_n,
  output logic              cpu_addr_oe_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_dq_oe,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fetch_miss
);

  localparam logic [2:0] FS   = 3'(FETCH_START);
  // last phase at which a CPU cycle may begin and still finish
  // before the display fetch slot
  localparam logic [2:0] WIN  = 3'(FETCH_START - 2 - ACCESS_CYCLES);
  localparam logic [1:0] LAST = 2'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    ACCESS,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] ph;
  logic [2:0] ph_nx;
  logic [1:0] cnt;
  logic [1:0] cnt_nx;
  logic       we_q;
  logic       slot_ok;
  logic       slot_ok_nx;
  logic       start;
  logic       busy_nx;
  logic       fetch_nx;
  logic       miss_nx;

  // load strobe forces the following cycle to phase 0
  assign ph_nx = !shload_n ? 3'd0 : ph + 3'd1;

  assign start = cpu.cpu_req &&
                 ((ph_nx <= WIN) || !video_active);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ph      <= '0;
      slot_ok <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ph      <= ph_nx;
      slot_ok <= slot_ok_nx;
      if (state == IDLE && start)
        we_q <= cpu.cpu_we;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = ADDR;
      end
      ADDR: begin
        state_nx = ACCESS;
        cnt_nx   = '0;
      end
      ACCESS: begin
        if (cnt == LAST)
          state_nx = DONE;
        else
          cnt_nx = cnt + 2'd1;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // The fetch decision is taken once per cell at the first slot
  // phase: a slot that collides with a CPU cycle is dropped whole,
  // and the collision is reported only if video was active.
  always_comb begin
    busy_nx    = (state_nx == ADDR) || (state_nx == ACCESS);
    slot_ok_nx = slot_ok;
    miss_nx    = 1'b0;
    if (ph_nx == FS) begin
      slot_ok_nx = video_active && !busy_nx;
      miss_nx    = video_active && busy_nx;
    end
    fetch_nx = (ph_nx >= FS) && slot_ok_nx && !busy_nx;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vga_oe_n      <= 1'b1;
      cpu_addr_oe_n <= 1'b1;
      mem_oe_n      <= 1'b1;
      mem_we_n      <= 1'b1;
      mem_dq_oe     <= 1'b0;
      mem_wdata     <= '0;
      fetch_miss    <= 1'b0;
      cpu.cpu_ack   <= 1'b0;
      cpu.cpu_rdata <= '0;
    end else begin
      vga_oe_n      <= !fetch_nx;
      cpu_addr_oe_n <= !busy_nx;
      mem_oe_n      <= !(fetch_nx ||
                         (state_nx == ACCESS && !we_q));
      mem_we_n      <= !(state_nx == ACCESS && we_q);
      mem_dq_oe     <= (state_nx == ACCESS) && we_q;
      fetch_miss    <= miss_nx;
      cpu.cpu_ack   <= (state_nx == DONE);
      if (state == IDLE && start)
        mem_wdata <= cpu.cpu_wdata;
      if (state == ACCESS && cnt == LAST && !we_q)
        cpu.cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter.
// Tracks the cell phase locally and checks every bus output per cycle.
module tb_vram_arbiter;

  logic       pclk;
  logic       rst;
  logic       shload_n;
  logic       video_active;
  logic       vga_oe_n;
  logic       cpu_addr_oe_n;
  logic       mem_oe_n;
  logic       mem_we_n;
  logic       mem_dq_oe;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       fetch_miss;

  logic [2:0] tb_ph;
  bit         force_load;
  int         checks;
  int         failures;

  vram_arbiter_if #(.DATA_W(8)) bus ();

  vram_arbiter #(
    .DATA_W(8),
    .ACCESS_CYCLES(2),
    .FETCH_START(5)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .shload_n(shload_n),
    .video_active(video_active),
    .cpu(bus),
    .vga_oe_n(vga_oe_n),
    .cpu_addr_oe_n(cpu_addr_oe_n),
    .mem_oe_n(mem_oe_n),
    .mem_we_n(mem_we_n),
    .mem_dq_oe(mem_dq_oe),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .fetch_miss(fetch_miss)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic step();
    shload_n = (force_load || tb_ph == 3'd7) ? 1'b0 : 1'b1;
    @(posedge pclk);
    #1;
    tb_ph = (shload_n == 1'b0) ? 3'd0 : tb_ph + 3'd1;
    force_load = 1'b0;
    shload_n = 1'b1;
    checks++;
    if ((vga_oe_n === 1'b0 && cpu_addr_oe_n === 1'b0) ||
        (mem_oe_n === 1'b0 && mem_we_n === 1'b0)) begin
      failures++;
      $display("FAIL invariant ph=%0d vga=%b addr=%b oe=%b we=%b",
               tb_ph, vga_oe_n, cpu_addr_oe_n, mem_oe_n, mem_we_n);
    end
  endtask

  task automatic advance_to(input logic [2:0] p);
    for (int n = 0; n < 16 && tb_ph != p; n++)
      step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tb_ph = 3'd0;
    checks++;
    if ({vga_oe_n, cpu_addr_oe_n, mem_oe_n, mem_we_n} !== 4'hF) begin
      failures++;
      $display("FAIL reset_n_outs got=%b exp=1111",
               {vga_oe_n, cpu_addr_oe_n, mem_oe_n, mem_we_n});
    end
    checks++;
    if ({bus.cpu_ack, fetch_miss, mem_dq_oe} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pulses got=%b exp=000",
               {bus.cpu_ack, fetch_miss, mem_dq_oe});
    end
    checks++;
    if (bus.cpu_rdata !== 8'h00 || mem_wdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_data rdata=%h wdata=%h exp=00",
               bus.cpu_rdata, mem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    logic e;
    video_active = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      e = !(tb_ph >= 3'd5);
      checks++;
      if (vga_oe_n !== e || mem_oe_n !== e || cpu_addr_oe_n !== 1'b1) begin
        failures++;
        $display("FAIL fetch ph=%0d vga=%b oe=%b addr=%b exp=%b,%b,1",
                 tb_ph, vga_oe_n, mem_oe_n, cpu_addr_oe_n, e, e);
      end
    end
  endtask

  task automatic test_resync();
    logic e;
    advance_to(3'd2);
    force_load = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      e = !(tb_ph >= 3'd5);
      checks++;
      if (vga_oe_n !== e) begin
        failures++;
        $display("FAIL resync ph=%0d vga=%b exp=%b", tb_ph, vga_oe_n, e);
      end
    end
  endtask

  task automatic test_write();
    logic ea;
    logic ew;
    logic ev;
    advance_to(3'd7);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_wdata = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      step();
      ea = !(tb_ph <= 3'd2);
      ew = !(tb_ph == 3'd1 || tb_ph == 3'd2);
      ev = !(tb_ph >= 3'd5);
      checks++;
      if (cpu_addr_oe_n !== ea || mem_we_n !== ew || mem_dq_oe !== !ew ||
          vga_oe_n !== ev || mem_oe_n !== ev ||
          bus.cpu_ack !== (tb_ph == 3'd3)) begin
        failures++;
        $display("FAIL write ph=%0d addr=%b we=%b dq=%b vga=%b oe=%b ack=%b exp=%b,%b,%b,%b,%b,%b",
                 tb_ph, cpu_addr_oe_n, mem_we_n, mem_dq_oe, vga_oe_n,
                 mem_oe_n, bus.cpu_ack, ea, ew, !ew, ev, ev, tb_ph == 3'd3);
      end
      if (!ew) begin
        checks++;
        if (mem_wdata !== 8'hA5) begin
          failures++;
          $display("FAIL write_data ph=%0d got=%h exp=a5", tb_ph, mem_wdata);
        end
      end
      if (tb_ph == 3'd3)
        bus.cpu_req = 1'b0;
    end
  endtask

  task automatic test_wait_read();
    logic ea;
    logic eo;
    advance_to(3'd3);
    bus.cpu_req = 1'b1;
    bus.cpu_we  = 1'b0;
    mem_rdata   = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      step();
      ea = !(i >= 4 && tb_ph <= 3'd2);
      eo = !(tb_ph >= 3'd5 || (i >= 4 && (tb_ph == 3'd1 || tb_ph == 3'd2)));
      checks++;
      if (cpu_addr_oe_n !== ea || mem_oe_n !== eo ||
          vga_oe_n !== !(tb_ph >= 3'd5) ||
          bus.cpu_ack !== (i == 7)) begin
        failures++;
        $display("FAIL wait ph=%0d addr=%b oe=%b vga=%b ack=%b exp=%b,%b,%b,%b",
                 tb_ph, cpu_addr_oe_n, mem_oe_n, vga_oe_n, bus.cpu_ack,
                 ea, eo, !(tb_ph >= 3'd5), i == 7);
      end
    end
    checks++;
    if (bus.cpu_rdata !== 8'h5A) begin
      failures++;
      $display("FAIL wait_rdata got=%h exp=5a", bus.cpu_rdata);
    end
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_read_blank();
    logic ea;
    logic eo;
    video_active = 1'b0;
    step();
    bus.cpu_req = 1'b1;
    bus.cpu_we  = 1'b0;
    mem_rdata   = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      step();
      ea = !(tb_ph >= 3'd5);
      eo = !(tb_ph == 3'd6 || tb_ph == 3'd7);
      checks++;
      if (cpu_addr_oe_n !== ea || mem_oe_n !== eo || vga_oe_n !== 1'b1 ||
          fetch_miss !== 1'b0 || bus.cpu_ack !== (tb_ph == 3'd0)) begin
        failures++;
        $display("FAIL blank_read ph=%0d addr=%b oe=%b vga=%b miss=%b ack=%b exp=%b,%b,1,0,%b",
                 tb_ph, cpu_addr_oe_n, mem_oe_n, vga_oe_n, fetch_miss,
                 bus.cpu_ack, ea, eo, tb_ph == 3'd0);
      end
    end
    checks++;
    if (bus.cpu_rdata !== 8'h3C) begin
      failures++;
      $display("FAIL blank_rdata got=%h exp=3c", bus.cpu_rdata);
    end
    bus.cpu_req = 1'b0;
    mem_rdata   = 8'h00;
    step();
    checks++;
    if (bus.cpu_rdata !== 8'h3C || bus.cpu_ack !== 1'b0) begin
      failures++;
      $display("FAIL rdata_hold rdata=%h ack=%b exp=3c,0",
               bus.cpu_rdata, bus.cpu_ack);
    end
  endtask

  task automatic test_fetch_miss();
    advance_to(3'd3);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_wdata = 8'h5A;
    step();
    checks++;
    if (cpu_addr_oe_n !== 1'b0) begin
      failures++;
      $display("FAIL miss_addr ph=%0d got=%b exp=0", tb_ph, cpu_addr_oe_n);
    end
    video_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (vga_oe_n !== 1'b1 || fetch_miss !== (tb_ph == 3'd5) ||
          bus.cpu_ack !== (tb_ph == 3'd7)) begin
        failures++;
        $display("FAIL miss ph=%0d vga=%b miss=%b ack=%b exp=1,%b,%b",
                 tb_ph, vga_oe_n, fetch_miss, bus.cpu_ack,
                 tb_ph == 3'd5, tb_ph == 3'd7);
      end
      if (tb_ph == 3'd7)
        bus.cpu_req = 1'b0;
    end
    advance_to(3'd5);
    checks++;
    if (vga_oe_n !== 1'b0 || fetch_miss !== 1'b0) begin
      failures++;
      $display("FAIL miss_recover vga=%b miss=%b exp=0,0",
               vga_oe_n, fetch_miss);
    end
  endtask

  task automatic test_reset_mid();
    video_active = 1'b0;
    advance_to(3'd3);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_wdata = 8'h11;
    step();
    step();
    checks++;
    if (mem_we_n !== 1'b0) begin
      failures++;
      $display("FAIL mid_access we=%b exp=0", mem_we_n);
    end
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    step();
    tb_ph = 3'd0;
    checks++;
    if ({vga_oe_n, cpu_addr_oe_n, mem_oe_n, mem_we_n} !== 4'hF ||
        mem_dq_oe !== 1'b0 || bus.cpu_ack !== 1'b0 ||
        mem_wdata !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset n=%b dq=%b ack=%b wd=%h exp=1111,0,0,00",
               {vga_oe_n, cpu_addr_oe_n, mem_oe_n, mem_we_n},
               mem_dq_oe, bus.cpu_ack, mem_wdata);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus.cpu_ack !== 1'b0 || cpu_addr_oe_n !== 1'b1) begin
        failures++;
        $display("FAIL post_reset i=%0d ack=%b addr=%b exp=0,1",
                 i, bus.cpu_ack, cpu_addr_oe_n);
      end
    end
  endtask

  task automatic test_back_to_back();
    bus.cpu_req = 1'b1;
    bus.cpu_we  = 1'b0;
    mem_rdata   = 8'hC3;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (bus.cpu_ack !== (i == 4 || i == 9)) begin
        failures++;
        $display("FAIL b2b i=%0d ack=%b exp=%b",
                 i, bus.cpu_ack, i == 4 || i == 9);
      end
    end
    bus.cpu_req = 1'b0;
    checks++;
    if (bus.cpu_rdata !== 8'hC3) begin
      failures++;
      $display("FAIL b2b_rdata got=%h exp=c3", bus.cpu_rdata);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    tb_ph         = 3'd0;
    force_load    = 1'b0;
    rst           = 1'b1;
    shload_n      = 1'b1;
    video_active  = 1'b0;
    mem_rdata     = 8'h00;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_wdata = 8'h00;
    test_reset();
    test_fetch();
    test_resync();
    test_write();
    test_wait_read();
    test_read_blank();
    test_fetch_miss();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
